// File: rtl/lease_sampler_drain_ctrl.sv
// Lease sampler sequencer: runs the sampler, flushes its table and drains the buffer to the host stream.
// Optional build macro LEASE_DRAIN_HEADER_EN prepends a header word to every drain.
module lease_sampler_drain_ctrl #(
  parameter int BUF_AW     = 13,
  parameter int READ_LAT   = 2,
  parameter int TABLE_WAIT = 128
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              run_i,
  input  logic              stop_i,
  input  logic              sampler_full_i,
  input  logic [BUF_AW:0]   buf_count_i,
  input  logic [31:0]       rd_interval_i,
  input  logic [31:0]       rd_pc_i,
  input  logic [31:0]       rd_target_i,
  input  logic [63:0]       rd_trace_i,
  output logic              sampler_en_o,
  output logic              sampler_clear_o,
  output logic              sampler_dump_o,
  output logic [BUF_AW-1:0] sampler_addr_o,
  output logic [31:0]       out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_MAX = (TABLE_WAIT > READ_LAT) ? TABLE_WAIT : READ_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic MODE_FULL  = 1'b0;
  localparam logic MODE_FINAL = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_FLUSH, S_SETUP, S_HDR, S_ADDR, S_WAIT, S_EMIT, S_CLEAR, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BUF_AW:0]   idx_q, idx_d;
  logic [BUF_AW:0]   n_q, n_d;
  logic [BUF_AW-1:0] addr_q, addr_d;
  logic [2:0]        wq_q, wq_d;
  logic              mode_q, mode_d;
  logic              stop_q, stop_d;
  logic [159:0]      hold_q, hold_d;
  logic [BUF_AW:0]   idx_inc;
  logic              last_entry;

  assign idx_inc    = idx_q + 1'b1;
  assign last_entry = (idx_inc == n_q);
  assign sampler_addr_o = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    addr_d  = addr_q;
    wq_d    = wq_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    hold_d  = hold_q;
    sampler_en_o    = 1'b0;
    sampler_clear_o = 1'b0;
    sampler_dump_o  = 1'b0;
    out_data_o      = '0;
    out_valid_o     = 1'b0;
    out_last_o      = 1'b0;
    busy_o          = (state_q != S_IDLE) && (state_q != S_RUN);
    done_o          = 1'b0;

    // An end-of-program stop arriving during a FULL drain must not be lost.
    if (stop_i && (mode_q == MODE_FULL) &&
        (state_q inside {S_SETUP, S_HDR, S_ADDR, S_WAIT, S_EMIT})) begin
      stop_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_RUN;
      end
      S_RUN: begin
        sampler_en_o = 1'b1;
        stop_d       = 1'b0;
        if (sampler_full_i) begin
          mode_d  = MODE_FULL;
          stop_d  = stop_i;
          state_d = S_SETUP;
        end else if (stop_i) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else if (!run_i) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        sampler_dump_o = (cnt_q == '0);
        if (cnt_q == CNT_W'(TABLE_WAIT - 1)) begin
          mode_d  = MODE_FINAL;
          stop_d  = 1'b0;
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETUP: begin
        n_d   = buf_count_i;
        idx_d = '0;
        wq_d  = '0;
`ifdef LEASE_DRAIN_HEADER_EN
        state_d = S_HDR;
`else
        if (buf_count_i == '0) begin
          state_d = S_CLEAR;
        end else begin
          addr_d  = '0;
          state_d = S_ADDR;
        end
`endif
      end
`ifdef LEASE_DRAIN_HEADER_EN
      S_HDR: begin
        out_valid_o = 1'b1;
        out_data_o  = {mode_q, 2'b00, 13'(n_q), 16'hD5A7};
        out_last_o  = (n_q == '0);
        if (out_ready_i) begin
          if (n_q == '0) begin
            state_d = S_CLEAR;
          end else begin
            addr_d  = '0;
            state_d = S_ADDR;
          end
        end
      end
`endif
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The address was presented on entry to ADDR, so data is valid READ_LAT cycles later.
        if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          hold_d  = {rd_trace_i, rd_target_i, rd_pc_i, rd_interval_i};
          wq_d    = '0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        out_valid_o = 1'b1;
        case (wq_q)
          3'd0:    out_data_o = hold_q[31:0];
          3'd1:    out_data_o = hold_q[63:32];
          3'd2:    out_data_o = hold_q[95:64];
          3'd3:    out_data_o = hold_q[127:96];
          3'd4:    out_data_o = hold_q[159:128];
          default: out_data_o = '0;
        endcase
        out_last_o = (wq_q == 3'd4) && last_entry;
        if (out_ready_i) begin
          if (wq_q == 3'd4) begin
            wq_d  = '0;
            idx_d = idx_inc;
            if (last_entry) begin
              state_d = S_CLEAR;
            end else begin
              addr_d  = idx_inc[BUF_AW-1:0];
              state_d = S_ADDR;
            end
          end else begin
            wq_d = wq_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        sampler_clear_o = 1'b1;
        if (mode_q == MODE_FINAL) begin
          state_d = S_DONE;
        end else if (stop_q || stop_i) begin
          stop_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (!run_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wq_q    <= '0;
      mode_q  <= MODE_FULL;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wq_q    <= wq_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
    end
  end

  // Entry data and the snapshot count are only observed in drain states, so they carry no reset.
  always_ff @(posedge clock_i) begin
    hold_q <= hold_d;
    n_q    <= n_d;
  end

endmodule
